tx_framer_8b10: RTL and testbench
=================================

// Module: tx_framer_8b10
// PURPOSE
//  Character-stream framer that sits directly upstream of encoder_8b10 and drives its din/kin/en inputs.
//  Packs a valid/ready byte stream into frames: K27.7 SOF (0xFB), data bytes (k=0), K29.7 EOF (0xFD).
//  Fills the link with K28.5 idles (0xBC) between frames, enforcing a minimum inter-frame gap.
//  Emits exactly one character per clock and flags underrun and over-length frames.
// PARAMETERS
//  IDLE_MIN  2    K28.5 characters between EOF and the next SOF (>=0; 0 = back-to-back frames)
//  MAX_LEN   256  maximum data bytes per frame (>=1); longer frames are truncated
//  CNT_W     16   width of frame_cnt
// PORTS
//  clk        in   1      clock
//  rst        in   1      asynchronous, active-high reset
//  s_data     in   8      payload byte
//  s_valid    in   1      s_data valid
//  s_last     in   1      s_data is the last byte of the frame
//  s_ready    out  1      byte accepted on this edge when s_valid & s_ready
//  enc_en     out  1      to encoder en
//  enc_din    out  8      to encoder din
//  enc_kin    out  1      to encoder kin (1 = control character)
//  underrun   out  1      1-cycle pulse, coincident with a fill character
//  len_err    out  1      1-cycle pulse, coincident with a forced EOF
//  frame_cnt  out  CNT_W  count of completed frames (EOF sent), wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, gap_cnt=IDLE_MIN (saturated), byte_cnt=0,
//   enc_en=0, enc_din=0xBC, enc_kin=1, underrun=0, len_err=0, frame_cnt=0.
//  All enc_*, underrun, len_err, frame_cnt are registered. enc_en=1 on every edge after reset release.
//  s_ready = (state==DATA), combinational from state only; it never depends on s_valid.
//  Latency: a byte accepted on edge N appears on enc_din/enc_kin=0 immediately after edge N.
//  States and per-edge actions:
//   IDLE:
//    - If gap_cnt>=IDLE_MIN and s_valid: emit 0xFB k=1, byte_cnt=0, go to DATA.
//      The byte is not consumed; s_ready is 0 in IDLE.
//    - Else: emit 0xBC k=1, gap_cnt+=1 (saturates at IDLE_MIN).
//   DATA:
//    - s_valid=1: emit s_data k=0 and byte_cnt+=1.
//      Go to EOF if s_last=1 or byte_cnt==MAX_LEN-1.
//      The second case without s_last is a forced EOF: set trunc flag.
//    - s_valid=0: emit 0xF7 (K23.7 fill) k=1, underrun=1 for this cycle.
//      Stay in DATA; byte_cnt is unchanged.
//   EOF:
//    - Emit 0xFD k=1, len_err=trunc, clear trunc.
//    - frame_cnt+=1, gap_cnt=0, go to IDLE.
//  Truncated frame: bytes following the forced EOF are framed as a new frame, after the normal gap.
//  IDLE_MIN=0: EOF is followed directly by SOF when s_valid is high (no K28.5 between frames).
//  MAX_LEN=1: every frame is SOF, one byte, EOF; len_err fires when that byte lacks s_last.
//  s_last with s_valid=0 is ignored. s_data and s_last are don't-care when s_valid=0.
//  Reset mid-frame: the frame is abandoned without EOF, frame_cnt is not incremented,
//   and outputs return to reset values immediately (no clock needed).
//  Upstream must hold s_data and s_last stable while s_valid=1 and s_ready=0.
// TESTING
//  1 Reset, s_valid=0 for 10 clk -> enc_en=0 during reset, then 1;
//    every character 0xBC k=1; frame_cnt=0.
//  2 IDLE_MIN=2; after idle, send 0x11,0x22,0x33(last) with no stalls
//    -> FB(k),11,22,33(k=0),FD(k),BC,BC; frame_cnt=1.
//  3 Drop s_valid for 2 cycles after byte 0x22
//    -> 11,22,F7,F7,33; underrun high on both F7 cycles only.
//  4 MAX_LEN=4; 6 bytes 0xA0..0xA5, s_last only on 0xA5
//    -> FB,A0..A3,FD (len_err=1),BC,BC,FB,A4,A5,FD (len_err=0); frame_cnt=2.
//  5 s_valid held high across two frames, IDLE_MIN=3
//    -> exactly 3 BC between FD and FB.
//  6 Assert rst mid-DATA, between edges
//    -> enc_din=0xBC, enc_kin=1, enc_en=0 asynchronously; frame_cnt unchanged; s_ready=0.

Source files
------------

// File: rtl/tx_framer_8b10.sv
// Character framer feeding encoder_8b10: SOF, payload bytes and EOF, with K28.5 idles between frames.
// Latency: a byte accepted on edge N is on enc_din immediately after edge N; one character per clock.
// Backpressure: s_ready is high only in DATA; a missing byte in DATA emits K23.7 fill and pulses underrun.
module tx_framer_8b10 #(
  parameter int IDLE_MIN = 2,
  parameter int MAX_LEN  = 256,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             enc_en,
  output logic [7:0]       enc_din,
  output logic             enc_kin,
  output logic             underrun,
  output logic             len_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_EOF  = 2'd2;

  localparam logic [7:0] K_SOF  = 8'hFB;  // K27.7
  localparam logic [7:0] K_EOF  = 8'hFD;  // K29.7
  localparam logic [7:0] K_IDLE = 8'hBC;  // K28.5
  localparam logic [7:0] K_FILL = 8'hF7;  // K23.7

  // One spare bit so IDLE_MIN itself is representable and 0 still yields a legal width.
  localparam int GAP_W  = $clog2(IDLE_MIN + 1) + 1;
  localparam int BYTE_W = $clog2(MAX_LEN) + 1;
  localparam logic [GAP_W-1:0]  GAP_SAT  = GAP_W'(IDLE_MIN);
  localparam logic [BYTE_W-1:0] LEN_LAST = BYTE_W'(MAX_LEN - 1);

  logic [1:0]        state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic              trunc;

  // Ready depends on state alone so upstream never sees a combinational loop through s_valid.
  assign s_ready = (state == ST_DATA);

  // Framing FSM and registered encoder-side outputs; one character leaves every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gap_cnt   <= GAP_SAT;
      byte_cnt  <= '0;
      trunc     <= 1'b0;
      enc_en    <= 1'b0;
      enc_din   <= K_IDLE;
      enc_kin   <= 1'b1;
      underrun  <= 1'b0;
      len_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      enc_en   <= 1'b1;
      underrun <= 1'b0;
      len_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The pending byte is left in place; SOF only announces it.
          if ((gap_cnt >= GAP_SAT) && s_valid) begin
            enc_din  <= K_SOF;
            enc_kin  <= 1'b1;
            byte_cnt <= '0;
            state    <= ST_DATA;
          end else begin
            enc_din <= K_IDLE;
            enc_kin <= 1'b1;
            if (gap_cnt < GAP_SAT) gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (s_valid) begin
            enc_din  <= s_data;
            enc_kin  <= 1'b0;
            byte_cnt <= byte_cnt + 1'b1;
            // Hitting the length limit without s_last closes the frame early; the rest
            // of the upstream packet becomes a new frame after the usual gap.
            if (s_last || (byte_cnt == LEN_LAST)) begin
              state <= ST_EOF;
              trunc <= ~s_last;
            end
          end else begin
            enc_din  <= K_FILL;
            enc_kin  <= 1'b1;
            underrun <= 1'b1;
          end
        end
        ST_EOF: begin
          enc_din   <= K_EOF;
          enc_kin   <= 1'b1;
          len_err   <= trunc;
          trunc     <= 1'b0;
          frame_cnt <= frame_cnt + 1'b1;
          gap_cnt   <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          enc_din <= K_IDLE;
          enc_kin <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_framer_8b10.sv
// Bench for tx_framer_8b10: three parameterisations share clock, reset, data and last.
// Per-cycle expected characters are queued when stimulus is driven and popped after the edge.
// Only the selected instance sees s_valid; the others idle.
module tb_tx_framer_8b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        vld [3];
  logic        rdy [3];
  logic        en  [3];
  logic [7:0]  din [3];
  logic        kin [3];
  logic        ur  [3];
  logic        le  [3];
  logic [15:0] fc  [3];

  typedef struct {
    logic [7:0] din;
    logic       kin;
    logic       ur;
    logic       le;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sel      = 0;

  always #5 clk = ~clk;

  tx_framer_8b10 #(.IDLE_MIN(2), .MAX_LEN(4), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(vld[0]), .s_last(s_last),
    .s_ready(rdy[0]), .enc_en(en[0]), .enc_din(din[0]), .enc_kin(kin[0]),
    .underrun(ur[0]), .len_err(le[0]), .frame_cnt(fc[0]));

  tx_framer_8b10 #(.IDLE_MIN(3), .MAX_LEN(256), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(vld[1]), .s_last(s_last),
    .s_ready(rdy[1]), .enc_en(en[1]), .enc_din(din[1]), .enc_kin(kin[1]),
    .underrun(ur[1]), .len_err(le[1]), .frame_cnt(fc[1]));

  tx_framer_8b10 #(.IDLE_MIN(0), .MAX_LEN(1), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(vld[2]), .s_last(s_last),
    .s_ready(rdy[2]), .enc_en(en[2]), .enc_din(din[2]), .enc_kin(kin[2]),
    .underrun(ur[2]), .len_err(le[2]), .frame_cnt(fc[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (inst %0d, t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  // One clock: drive on the falling edge, check ready, queue the expected character,
  // then compare what the selected instance emits just after the rising edge.
  task automatic cyc(input string tag, input logic v, input logic [7:0] d, input logic l,
                     input logic e_rdy, input logic [7:0] e_din, input logic e_kin,
                     input logic e_ur, input logic e_le);
    exp_t e;
    exp_t got;
    @(negedge clk);
    for (int i = 0; i < 3; i++) vld[i] = (i == sel) ? v : 1'b0;
    s_data = d;
    s_last = l;
    #1;
    check({tag, "_rdy"}, 32'(rdy[sel]), 32'(e_rdy));
    e.din = e_din; e.kin = e_kin; e.ur = e_ur; e.le = e_le;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check({tag, "_din"}, 32'(din[sel]), 32'(got.din));
      check({tag, "_kin"}, 32'(kin[sel]), 32'(got.kin));
      check({tag, "_ur"},  32'(ur[sel]),  32'(got.ur));
      check({tag, "_le"},  32'(le[sel]),  32'(got.le));
      check({tag, "_en"},  32'(en[sel]),  32'd1);
    end
  endtask

  // Idle character with nothing offered.
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 8'h00, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;

    // Reset state, held for a few clocks.
    sel = 0;
    repeat (3) @(negedge clk);
    check("rst_en",  32'(en[0]),  32'd0);
    check("rst_din", 32'(din[0]), 32'hBC);
    check("rst_kin", 32'(kin[0]), 32'd1);
    check("rst_ur",  32'(ur[0]),  32'd0);
    check("rst_le",  32'(le[0]),  32'd0);
    check("rst_fc",  32'(fc[0]),  32'd0);
    check("rst_rdy", 32'(rdy[0]), 32'd0);
    rst = 1'b0;

    // Idle link after reset release.
    idle("t1", 10);
    check("t1_fc", 32'(fc[0]), 32'd0);

    // Reset in the middle of a frame on the IDLE_MIN=3 instance.
    sel = 1;
    cyc("t6", 1'b1, 8'hC0, 1'b0, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b0);
    cyc("t6", 1'b1, 8'hC0, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_en",  32'(en[1]),  32'd0);
    check("t6_async_din", 32'(din[1]), 32'hBC);
    check("t6_async_kin", 32'(kin[1]), 32'd1);
    check("t6_async_rdy", 32'(rdy[1]), 32'd0);
    check("t6_async_fc",  32'(fc[1]),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // s_valid held across two frames: exactly three K28.5 between FD and FB.
    cyc("t5", 1'b1, 8'hD0, 1'b0, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b0);
    cyc("t5", 1'b1, 8'hD0, 1'b0, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
    cyc("t5", 1'b1, 8'hD1, 1'b1, 1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
    cyc("t5", 1'b1, 8'hE0, 1'b1, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("t5_gap", 1'b1, 8'hE0, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0);
    cyc("t5", 1'b1, 8'hE0, 1'b1, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b0);
    cyc("t5", 1'b1, 8'hE0, 1'b1, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
    cyc("t5", 1'b0, 8'h00, 1'b0, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b0);
    cyc("t5", 1'b0, 8'h00, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0);
    check("t5_fc", 32'(fc[1]), 32'd2);

    // Plain three-byte frame, IDLE_MIN=2.
    sel = 0;
    cyc("t2", 1'b1, 8'h11, 1'b0, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b0);
    cyc("t2", 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc("t2", 1'b1, 8'h22, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cyc("t2", 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    cyc("t2", 1'b0, 8'h00, 1'b0, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b0);
    idle("t2_gap", 2);
    check("t2_fc", 32'(fc[0]), 32'd1);

    // Two-cycle stall after 0x22: K23.7 fill with underrun on both cycles.
    cyc("t3", 1'b1, 8'h11, 1'b0, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b0);
    cyc("t3", 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc("t3", 1'b1, 8'h22, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cyc("t3_fill", 1'b0, 8'h00, 1'b1, 1'b1, 8'hF7, 1'b1, 1'b1, 1'b0);
    cyc("t3_fill", 1'b0, 8'h00, 1'b0, 1'b1, 8'hF7, 1'b1, 1'b1, 1'b0);
    cyc("t3", 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    cyc("t3", 1'b0, 8'h00, 1'b0, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b0);
    idle("t3_gap", 2);
    check("t3_fc", 32'(fc[0]), 32'd2);

    // Six bytes with MAX_LEN=4: forced EOF after A3, remainder framed after the gap.
    cyc("t4", 1'b1, 8'hA0, 1'b0, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("t4", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    cyc("t4_trunc", 1'b1, 8'hA4, 1'b0, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b1);
    cyc("t4_gap", 1'b1, 8'hA4, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0);
    cyc("t4_gap", 1'b1, 8'hA4, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0);
    cyc("t4", 1'b1, 8'hA4, 1'b0, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b0);
    cyc("t4", 1'b1, 8'hA4, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
    cyc("t4", 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc("t4_eof", 1'b0, 8'h00, 1'b0, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b0);
    idle("t4_gap", 2);
    check("t4_fc", 32'(fc[0]), 32'd4);

    // Exactly MAX_LEN bytes with s_last on the final one: no length error.
    cyc("t7", 1'b1, 8'hB0, 1'b0, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("t7", 1'b1, 8'hB0 + 8'(i), (i == 3), 1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0);
    cyc("t7_eof", 1'b0, 8'h00, 1'b0, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b0);
    idle("t7_gap", 1);
    check("t7_fc", 32'(fc[0]), 32'd5);

    // IDLE_MIN=0, MAX_LEN=1: one-byte frames back to back, first one truncated.
    sel = 2;
    cyc("t8", 1'b1, 8'hF0, 1'b0, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b0);
    cyc("t8", 1'b1, 8'hF0, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    cyc("t8_trunc", 1'b1, 8'hF1, 1'b1, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b1);
    cyc("t8_b2b", 1'b1, 8'hF1, 1'b1, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b0);
    cyc("t8", 1'b1, 8'hF1, 1'b1, 1'b1, 8'hF1, 1'b0, 1'b0, 1'b0);
    cyc("t8_eof", 1'b0, 8'h00, 1'b0, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b0);
    idle("t8_idle", 1);
    check("t8_fc", 32'(fc[2]), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
